// File: rtl/stack_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : stack_fetch_stage
// Purpose  : Stack CPU fetch stage. Owns the instruction memory and the PC,
//            and delivers one registered instruction per cycle downstream.
// Revision : 1.0 - initial release
// ============================================================================
module stack_fetch_stage #(
  parameter int          IM_DEPTH = 128,
  parameter int          ADDR_W   = 7,
  parameter int          DATA_W   = 32,
  parameter logic [5:0]  HALT_OP  = 6'h3F
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              im_we,
  input  logic [ADDR_W-1:0] im_waddr,
  input  logic [DATA_W-1:0] im_wdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t r_state;

  // Not reset: the program survives reset so it can be reloaded or rerun.
  logic [DATA_W-1:0] IM [0:IM_DEPTH-1];

  logic [DATA_W-1:0] w_word;
  logic              w_is_halt;

  assign w_word    = IM[pc];
  assign w_is_halt = (w_word[DATA_W-1 -: 6] == HALT_OP);

  // Nonblocking write makes a same-address fetch see the old word.
  always_ff @(posedge clock) begin
    if (im_we && !reset) begin
      IM[im_waddr] <= im_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= FETCH;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (redirect_valid) begin
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
          end else if (!stall) begin
            instr       <= w_word;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            if (w_is_halt) begin
              r_state <= HALT;
              halted  <= 1'b1;
            end else begin
              // Wraps at the top of memory since IM_DEPTH == 2**ADDR_W.
              pc <= pc + ADDR_W'(1);
            end
          end
        end
        HALT: begin
          if (redirect_valid) begin
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            r_state     <= FETCH;
          end else if (!stall) begin
            instr_valid <= 1'b0;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_fetch_stage.sv
`default_nettype none
// Testbench for stack_fetch_stage: directed vector table followed by random
// traffic checked against a behavioural model of the fetch stage.
module tb_stack_fetch_stage;

  logic        clock = 1'b0;
  logic        reset, stall, redirect_valid, im_we;
  logic [6:0]  redirect_pc, im_waddr;
  logic [31:0] im_wdata;
  logic [31:0] instr;
  logic [6:0]  instr_pc, pc;
  logic        instr_valid, halted;

  int n_cmp  = 0;
  int n_fail = 0;

  stack_fetch_stage dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .pc(pc), .halted(halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, stl, rv;
    logic [6:0]  rpc;
    logic        we;
    logic [6:0]  wa;
    logic [31:0] wd;
    logic [31:0] e_instr;
    logic [6:0]  e_ipc;
    logic        e_v;
    logic [6:0]  e_pc;
    logic        e_h;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: memory image plus the architecturally visible outputs.
  logic [31:0] m_mem [0:127];
  logic [31:0] m_instr;
  logic [6:0]  m_ipc, m_pc;
  logic        m_v, m_h;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, stl, rv, input logic [6:0] rpc,
                              input logic we, input logic [6:0] wa, input logic [31:0] wd,
                              input logic [31:0] ei, input logic [6:0] eipc,
                              input logic ev, input logic [6:0] epc, input logic eh);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rv = rv; v.rpc = rpc; v.we = we; v.wa = wa; v.wd = wd;
    v.e_instr = ei; v.e_ipc = eipc; v.e_v = ev; v.e_pc = epc; v.e_h = eh;
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [31:0] word;
    word = m_mem[m_pc];
    if (reset) begin
      m_pc = 0; m_instr = 0; m_ipc = 0; m_v = 0; m_h = 0;
    end else begin
      if (redirect_valid) begin
        m_pc = redirect_pc; m_v = 0; m_h = 0;
      end else if (stall) begin
        // everything holds
      end else if (m_h) begin
        m_v = 0;
      end else begin
        m_instr = word; m_ipc = m_pc; m_v = 1;
        if (word[31:26] == 6'h3F) m_h = 1;
        else m_pc = 7'((int'(m_pc) + 1) % 128);
      end
      if (im_we) m_mem[im_waddr] = im_wdata;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rst, stl, rv, input logic [6:0] rpc,
                       input logic we, input logic [6:0] wa, input logic [31:0] wd);
    reset = rst; stall = stl; redirect_valid = rv; redirect_pc = rpc;
    im_we = we; im_waddr = wa; im_wdata = wd;
  endtask

  task automatic check_all(input string tag, input logic [31:0] ei, input logic [6:0] eipc,
                           input logic ev, input logic [6:0] epc, input logic eh);
    check({tag, ".instr"},       instr,       ei);
    check({tag, ".instr_pc"},    32'(instr_pc), 32'(eipc));
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'(ev));
    check({tag, ".pc"},          32'(pc),     32'(epc));
    check({tag, ".halted"},      32'(halted), 32'(eh));
  endtask

  function automatic logic [31:0] prog(input int a);
    case (a)
      0:   return 32'h0400_0000;
      1:   return 32'h0800_0000;
      2:   return 32'h0C00_0000;
      3:   return 32'hFC00_0000;
      40:  return 32'hAAAA_0028;
      126: return 32'h0A00_007E;
      127: return 32'h0B00_007F;
      default: return 32'h0100_0000 | 32'(a);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) m_mem[i] = 32'h0;
    m_pc = 0; m_instr = 0; m_ipc = 0; m_v = 0; m_h = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    // Program load while stalled at pc 0
    for (int i = 0; i < 128; i++) begin
      drive(0, 1, 0, 0, 1, 7'(i), prog(i));
      tick();
    end
    // Reset for 10 cycles; outputs must read as the reset values throughout
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      check_all("reset", 0, 0, 0, 0, 0);
    end

    //        rst stl rv rpc we wa  wd             instr          ipc v  pc  h
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'h0400_0000, 0,  1, 1,  0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'h0800_0000, 1,  1, 2,  0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'h0C00_0000, 2,  1, 3,  0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'hFC00_0000, 3,  1, 3,  1));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'hFC00_0000, 3,  0, 3,  1));
    tbl.push_back(mk(0,1,0,0,  0,0,0,            32'hFC00_0000, 3,  0, 3,  1));
    tbl.push_back(mk(0,0,1,0,  0,0,0,            32'hFC00_0000, 3,  0, 0,  0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'h0400_0000, 0,  1, 1,  0));
    tbl.push_back(mk(0,0,1,4,  0,0,0,            32'h0400_0000, 0,  0, 4,  0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'h0100_0004, 4,  1, 5,  0));
    tbl.push_back(mk(0,1,0,0,  0,0,0,            32'h0100_0004, 4,  1, 5,  0));
    tbl.push_back(mk(0,1,0,0,  0,0,0,            32'h0100_0004, 4,  1, 5,  0));
    tbl.push_back(mk(0,1,0,0,  0,0,0,            32'h0100_0004, 4,  1, 5,  0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'h0100_0005, 5,  1, 6,  0));
    tbl.push_back(mk(0,1,1,40, 0,0,0,            32'h0100_0005, 5,  0, 40, 0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'hAAAA_0028, 40, 1, 41, 0));
    tbl.push_back(mk(0,0,1,126,0,0,0,            32'hAAAA_0028, 40, 0, 126,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'h0A00_007E, 126,1, 127,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'h0B00_007F, 127,1, 0,  0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'h0400_0000, 0,  1, 1,  0));
    tbl.push_back(mk(0,0,1,10, 0,0,0,            32'h0400_0000, 0,  0, 10, 0));
    tbl.push_back(mk(0,0,0,0,  1,10,32'h1234_5678,32'h0100_000A, 10, 1, 11, 0));
    tbl.push_back(mk(0,0,1,10, 0,0,0,            32'h0100_000A, 10, 0, 10, 0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'h1234_5678, 10, 1, 11, 0));
    tbl.push_back(mk(0,0,1,3,  0,0,0,            32'h1234_5678, 10, 0, 3,  0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'hFC00_0000, 3,  1, 3,  1));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'hFC00_0000, 3,  0, 3,  1));
    tbl.push_back(mk(1,1,1,50, 1,0,32'hDEAD_BEEF,32'h0,         0,  0, 0,  0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,            32'h0400_0000, 0,  1, 1,  0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].stl, tbl[i].rv, tbl[i].rpc, tbl[i].we, tbl[i].wa, tbl[i].wd);
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].e_instr, tbl[i].e_ipc, tbl[i].e_v,
                tbl[i].e_pc, tbl[i].e_h);
    end

    // HALT held for 20 cycles, then redirect resumes fetch at IM[0]
    drive(0, 0, 1, 3, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      check_all("halt_hold", 32'hFC00_0000, 3, 0, 3, 1);
    end
    drive(0, 0, 1, 0, 0, 0, 0); tick();
    check_all("halt_exit", 32'hFC00_0000, 3, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    check_all("halt_resume", 32'h0400_0000, 0, 1, 1, 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] wd;
      wd = $urandom;
      if ($urandom_range(0, 7) == 0) wd[31:26] = 6'h3F;
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, 7'($urandom_range(0, 127)),
            $urandom_range(0, 4) == 0, 7'($urandom_range(0, 127)), wd);
      tick();
      check_all("rand", m_instr, m_ipc, m_v, m_pc, m_h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
